// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling 8N1/8E1/8O1 receive datapath feeding the UART control block.
// Build option UART_RX_FIFO_EN swaps the single holding register for a 4-entry receive FIFO.
module uart_rx_core #(
  parameter int DIV_W = 16,
  parameter int OSR   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             uart_rxd,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             rd_data_flag,
  output logic [7:0]       data_reg_rd,
  output logic             rx_ok,
  output logic             parity_error,
  output logic             frame_error,
  output logic             overrun
);

  localparam int OS_W = $clog2(OSR);

  // Encoding is stable so checkers can compare the state value directly.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic             rxd_m, rxd_s;
  logic [DIV_W-1:0] pre_cnt;
  logic [OS_W-1:0]  os_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             perr;
  logic             tick, mid_start, bit_end;
  logic             restart, clr_os, sample_bit, sample_par, load;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= uart_rxd;
      rxd_s <= rxd_m;
    end
  end

  assign tick      = (pre_cnt == '0);
  assign mid_start = tick && (os_cnt == OS_W'(OSR/2 - 1));
  assign bit_end   = tick && (os_cnt == {OS_W{1'b1}});

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    restart    = 1'b0;
    clr_os     = 1'b0;
    sample_bit = 1'b0;
    sample_par = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (!rxd_s) begin
          state_nxt = START;
          restart   = 1'b1;
        end
      end
      START: begin
        if (mid_start) begin
          if (rxd_s) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = DATA;
            clr_os    = 1'b1;
          end
        end
      end
      DATA: begin
        if (bit_end) begin
          sample_bit = 1'b1;
          if (bit_cnt == 3'd7) state_nxt = parity_en ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) begin
          sample_par = 1'b1;
          state_nxt  = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          load      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counters restart on the start edge so every sample lands relative to it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      os_cnt  <= '0;
    end else begin
      if (restart)   pre_cnt <= '0;
      else if (tick) pre_cnt <= baud_div;
      else           pre_cnt <= pre_cnt - DIV_W'(1);
      if (restart || clr_os) os_cnt <= '0;
      else if (tick)         os_cnt <= os_cnt + OS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      shift   <= '0;
      perr    <= 1'b0;
    end else begin
      if (restart) begin
        bit_cnt <= '0;
        perr    <= 1'b0;
      end else begin
        if (sample_bit) begin
          bit_cnt <= bit_cnt + 3'd1;
          shift   <= {rxd_s, shift[7:1]};
        end
        if (sample_par) perr <= ((^shift) ^ rxd_s) != parity_odd;
      end
    end
  end

  // rd_data_flag is a one-cycle consume strobe from the control block; a load in
  // the same cycle wins, since the read consumed the previous byte, not the new one.
`ifdef UART_RX_FIFO_EN
  logic [9:0] mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  logic       ovr_q, full, pop, push;

  assign full = (count == 3'd4);
  assign pop  = rd_data_flag && (count != 3'd0);
  assign push = load && (!full || pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovr_q  <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {~rxd_s, perr, shift};
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      if (load && full && !pop) ovr_q <= 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  assign {frame_error, parity_error, data_reg_rd} = mem[rd_ptr];
  assign rx_ok   = (count != 3'd0);
  assign overrun = ovr_q;
`else
  logic [7:0] data_q;
  logic       ok_q, pe_q, fe_q, ovr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      ok_q   <= 1'b0;
      pe_q   <= 1'b0;
      fe_q   <= 1'b0;
      ovr_q  <= 1'b0;
    end else if (load) begin
      data_q <= shift;
      pe_q   <= perr;
      fe_q   <= ~rxd_s;
      ok_q   <= 1'b1;
      if (ok_q && !rd_data_flag) ovr_q <= 1'b1;
    end else if (rd_data_flag) begin
      ok_q <= 1'b0;
    end
  end

  assign data_reg_rd  = data_q;
  assign rx_ok        = ok_q;
  assign parity_error = pe_q;
  assign frame_error  = fe_q;
  assign overrun      = ovr_q;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: table-driven frames plus corner sequences, checked against an expected queue.
// Works in both builds; the queue depth follows UART_RX_FIFO_EN.
module tb_uart_rx_core;

`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic        uart_rxd;
  logic [15:0] baud_div;
  logic        parity_en;
  logic        parity_odd;
  logic        rd_data_flag;
  logic [7:0]  data_reg_rd;
  logic        rx_ok;
  logic        parity_error;
  logic        frame_error;
  logic        overrun;

  uart_rx_core #(.DIV_W(16), .OSR(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .uart_rxd     (uart_rxd),
    .baud_div     (baud_div),
    .parity_en    (parity_en),
    .parity_odd   (parity_odd),
    .rd_data_flag (rd_data_flag),
    .data_reg_rd  (data_reg_rd),
    .rx_ok        (rx_ok),
    .parity_error (parity_error),
    .frame_error  (frame_error),
    .overrun      (overrun)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   last_rise = -1;
  logic ok_prev   = 1'b0;
  always @(negedge clk) begin
    if (rx_ok && !ok_prev) last_rise = cyc;
    ok_prev = rx_ok;
  end

  initial begin
    #900000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  int         checks   = 0;
  int         failures = 0;
  logic [9:0] exp_q[$];
  logic       exp_overrun = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic sb_push(input logic fe, input logic pe, input logic [7:0] d);
    if (exp_q.size() == DEPTH) begin
      exp_overrun = 1'b1;
      if (DEPTH == 1) exp_q[0] = {fe, pe, d};
    end else begin
      exp_q.push_back({fe, pe, d});
    end
  endtask

  task automatic sb_pop();
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  task automatic check_head(input string tag);
    @(negedge clk);
    check({tag, "_rx_ok"}, 32'(rx_ok), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check({tag, "_data"}, 32'(data_reg_rd), 32'(exp_q[0][7:0]));
      check({tag, "_perr"}, 32'(parity_error), 32'(exp_q[0][8]));
      check({tag, "_ferr"}, 32'(frame_error), 32'(exp_q[0][9]));
    end
    check({tag, "_overrun"}, 32'(overrun), 32'(exp_overrun));
  endtask

  // driver tasks
  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_rd();
    rd_data_flag = 1'b1;
    hold(1);
    rd_data_flag = 1'b0;
    sb_pop();
  endtask

  int fall_cyc = 0;

  // Drives one character; abort_at >= 0 returns halfway through that data bit.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic stop, input int div, input int abort_at);
    int bitc;
    bitc     = 16 * (div + 1);
    fall_cyc = cyc;
    uart_rxd = 1'b0;
    hold(bitc);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = d[i];
      if (i == abort_at) begin
        hold(bitc / 2);
        return;
      end
      hold(bitc);
    end
    if (pen) begin
      uart_rxd = pbit;
      hold(bitc);
    end
    if (stop) begin
      uart_rxd = 1'b1;
      hold(bitc);
    end else begin
      // low through the mid-bit sample, then back to idle so no real start follows
      uart_rxd = 1'b0;
      hold(bitc * 10 / 16);
      uart_rxd = 1'b1;
      hold(bitc * 6 / 16);
    end
    hold(bitc);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       pen;
    logic       podd;
    logic       pbit;
    logic       stop;
    int         div;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int   exp_lat, lat, tol;
    logic seen;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b0, 1'b0};
    vecs[1] = '{8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 3, 1'b0, 1'b0};
    vecs[2] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 3, 1'b1, 1'b0};
    vecs[3] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b0};
    vecs[4] = '{8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b0};
    vecs[5] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0};
    vecs[6] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0};
    vecs[7] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b1};
    vecs[8] = '{8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b0};

    rst_n        = 1'b0;
    uart_rxd     = 1'b1;
    baud_div     = 16'd3;
    parity_en    = 1'b0;
    parity_odd   = 1'b0;
    rd_data_flag = 1'b0;
    hold(3);
    check_head("reset");
    check("reset_state", 32'(dut.state), 32'd0);
    rst_n = 1'b1;
    hold(5);

    // table of characters
    for (int v = 0; v < 9; v++) begin
      baud_div   = 16'(vecs[v].div);
      parity_en  = vecs[v].pen;
      parity_odd = vecs[v].podd;
      hold(2);
      sb_push(vecs[v].exp_fe, vecs[v].exp_pe, vecs[v].data);
      send_frame(vecs[v].data, vecs[v].pen, vecs[v].pbit, vecs[v].stop, vecs[v].div, -1);
      tol     = vecs[v].div + 1;
      exp_lat = 2 + (19 + 2 * int'(vecs[v].pen)) * 8 * (vecs[v].div + 1);
      lat     = last_rise - fall_cyc;
      checks++;
      if (last_rise <= fall_cyc || lat < exp_lat - tol || lat > exp_lat + tol) begin
        failures++;
        $display("FAIL latency_vec%0d actual=%0d required=%0d+-%0d", v, lat, exp_lat, tol);
      end
      check_head($sformatf("vec%0d", v));
      pulse_rd();
      check_head($sformatf("vec%0d_read", v));
`ifndef UART_RX_FIFO_EN
      check($sformatf("vec%0d_perr_kept", v), 32'(parity_error), 32'(vecs[v].exp_pe));
      check($sformatf("vec%0d_ferr_kept", v), 32'(frame_error), 32'(vecs[v].exp_fe));
`endif
    end

    // start glitch: 20-clock low pulse
    baud_div  = 16'd3;
    parity_en = 1'b0;
    hold(2);
    uart_rxd = 1'b0;
    hold(10);
    @(negedge clk);
    check("glitch_in_start", 32'(dut.state), 32'd1);
    hold(9);
    uart_rxd = 1'b1;
    hold(40);
    check_head("glitch");
    check("glitch_idle", 32'(dut.state), 32'd0);

    // two bytes without a read
    sb_push(1'b0, 1'b0, 8'h11);
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 3, -1);
    sb_push(1'b0, 1'b0, 8'h22);
    send_frame(8'h22, 1'b0, 1'b0, 1'b1, 3, -1);
    check_head("overrun");
    for (int k = 0; k < DEPTH && exp_q.size() != 0; k++) begin
      pulse_rd();
      check_head($sformatf("overrun_read%0d", k));
    end

    // reset in the middle of data bit 4
    send_frame(8'h96, 1'b0, 1'b0, 1'b1, 3, 4);
    check("abort_in_data", 32'(dut.state), 32'd2);
    rst_n    = 1'b0;
    uart_rxd = 1'b1;
    exp_q.delete();
    exp_overrun = 1'b0;
    hold(2);
    check_head("mid_reset");
    check("mid_reset_state", 32'(dut.state), 32'd0);
    rst_n = 1'b1;
    hold(40);
    check_head("after_reset");
    sb_push(1'b0, 1'b0, 8'h5A);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 3, -1);
    check_head("post_reset_5a");
    pulse_rd();
    check_head("post_reset_read");

    // read strobe held so it coincides with the load cycle
    seen         = 1'b0;
    rd_data_flag = 1'b1;
    sb_push(1'b0, 1'b0, 8'h33);
    fork
      send_frame(8'h33, 1'b0, 1'b0, 1'b1, 3, -1);
      begin
        for (int k = 0; k < 2000; k++) begin
          @(negedge clk);
          if (rx_ok) begin
            seen = 1'b1;
            break;
          end
        end
        rd_data_flag = 1'b0;
      end
    join
    check("collision_load_seen", 32'(seen), 32'd1);
    check_head("collision");
    pulse_rd();
    check_head("collision_read");

    // burst of five bytes without reads
    baud_div = 16'd0;
    hold(2);
    for (int b = 1; b <= 5; b++) begin
      sb_push(1'b0, 1'b0, 8'(b));
      send_frame(8'(b), 1'b0, 1'b0, 1'b1, 0, -1);
    end
    check_head("burst");
    for (int k = 0; k < 4 && exp_q.size() != 0; k++) begin
      pulse_rd();
      check_head($sformatf("burst_pop%0d", k));
    end

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
